// File: rtl/seq_detector.sv
// Serial pattern detector with a same-cycle Mealy match pulse.
// It also keeps a saturating match counter with a sticky overflow flag.
module seq_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         clr_count,
    output logic                         z,
    output logic [$clog2(PATTERN_W)-1:0] fill,
    output logic [CNT_W-1:0]             match_count,
    output logic                         overflow
);

    localparam int FW = $clog2(PATTERN_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PATTERN_W - 1);

    logic [PATTERN_W-2:0] hist;
    logic [PATTERN_W-1:0] window;
    logic                 full;

    // The shifted history is the window minus its oldest bit.
    // This form also covers PATTERN_W=2, where hist is a single bit.
    assign window = {hist, x};
    assign full   = (fill == FILL_MAX);
    assign z      = reset & x_valid & full & (window == PATTERN);

    // History shift register and fill level, advanced on valid bits only
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= window[PATTERN_W-2:0];
            if (z && !OVERLAP) begin
                fill <= '0;
            end else if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Saturating match counter; a clear that coincides with a match counts it
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clr_count) begin
            match_count <= z ? CNT_W'(1) : '0;
            overflow    <= 1'b0;
        end else if (z) begin
            if (&match_count) begin
                overflow <= 1'b1;
            end else begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector.
// Three instances: overlapping 1011, non-overlapping 1011, saturating 1111.
module tb_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;
    logic clr = 1'b0;

    logic       z_a, z_b, z_c;
    logic [1:0] fill_a, fill_b, fill_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       ovf_a, ovf_b, ovf_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_detector #(
        .PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)
    ) u_a (
        .clk(clk), .reset(rst), .x(x), .x_valid(x_valid),
        .clr_count(clr), .z(z_a), .fill(fill_a),
        .match_count(cnt_a), .overflow(ovf_a)
    );

    seq_detector #(
        .PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)
    ) u_b (
        .clk(clk), .reset(rst), .x(x), .x_valid(x_valid),
        .clr_count(clr), .z(z_b), .fill(fill_b),
        .match_count(cnt_b), .overflow(ovf_b)
    );

    seq_detector #(
        .PATTERN_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)
    ) u_c (
        .clk(clk), .reset(rst), .x(x), .x_valid(x_valid),
        .clr_count(clr), .z(z_c), .fill(fill_c),
        .match_count(cnt_c), .overflow(ovf_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; checks run 1 time unit later,
    // so registers show the state left by the previous rising edge.
    task automatic drive(input logic xb, input logic v,
                         input logic c, input logic r);
        @(negedge clk);
        x = xb;
        x_valid = v;
        clr = c;
        rst = r;
        #1;
    endtask

    initial begin
        // reset state
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        chk("rst_z_a", z_a, 0);
        chk("rst_fill_a", fill_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_cnt_c", cnt_c, 0);

        // overlapping / non-overlapping stream 1,0,1,1,0,1,1
        drive(1, 1, 0, 1);
        chk("s1_z_a", z_a, 0);
        drive(0, 1, 0, 1);
        chk("s2_z_a", z_a, 0);
        drive(1, 1, 0, 1);
        chk("s3_z_a", z_a, 0);
        chk("s3_fill_a", fill_a, 2);
        drive(1, 1, 0, 1);
        chk("s4_z_a", z_a, 1);
        chk("s4_z_b", z_b, 1);
        chk("s4_z_c", z_c, 0);
        chk("s4_fill_a", fill_a, 3);
        drive(0, 1, 0, 1);
        chk("s5_z_a", z_a, 0);
        chk("s5_fill_b", fill_b, 0);
        chk("s5_cnt_a", cnt_a, 1);
        drive(1, 1, 0, 1);
        chk("s6_z_a", z_a, 0);
        chk("s6_fill_b", fill_b, 1);
        drive(1, 1, 0, 1);
        chk("s7_z_a", z_a, 1);
        chk("s7_z_b", z_b, 0);
        chk("s7_fill_b", fill_b, 2);
        drive(0, 0, 0, 1);
        chk("s8_fill_b", fill_b, 3);
        chk("s8_cnt_a", cnt_a, 2);
        chk("s8_cnt_b", cnt_b, 1);
        chk("s8_cnt_c", cnt_c, 0);

        // gapped input: 1,0,1, three idle cycles with x=1, then 1
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("g_rst_fill_a", fill_a, 0);
        chk("g_rst_cnt_a", cnt_a, 0);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 1);
        chk("g3_z_a", z_a, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1);
            chk("gap_z_a", z_a, 0);
            chk("gap_z_b", z_b, 0);
            chk("gap_fill_a", fill_a, 3);
        end
        drive(1, 1, 0, 1);
        chk("g4_z_a", z_a, 1);
        chk("g4_z_b", z_b, 1);
        chk("g4_z_c", z_c, 0);
        drive(0, 0, 0, 1);
        chk("g5_cnt_a", cnt_a, 1);
        chk("g5_fill_a", fill_a, 3);
        chk("g5_fill_b", fill_b, 0);

        // mid-sequence reset with the completing bit present
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 0);
        chk("mr_z_a", z_a, 0);
        chk("mr_z_b", z_b, 0);
        drive(1, 1, 0, 1);
        chk("mr1_z_a", z_a, 0);
        chk("mr1_fill_a", fill_a, 0);
        chk("mr1_cnt_a", cnt_a, 0);
        drive(0, 0, 0, 1);
        chk("mr2_fill_a", fill_a, 1);
        chk("mr2_cnt_a", cnt_a, 0);

        // saturation on the 1111 / CNT_W=2 instance
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sat_rst_cnt_c", cnt_c, 0);
        drive(1, 1, 0, 1);
        chk("sat1_z_c", z_c, 0);
        drive(1, 1, 0, 1);
        chk("sat2_z_c", z_c, 0);
        drive(1, 1, 0, 1);
        chk("sat3_z_c", z_c, 0);
        drive(1, 1, 0, 1);
        chk("sat4_z_c", z_c, 1);
        chk("sat4_z_a", z_a, 0);
        chk("sat4_cnt_c", cnt_c, 0);
        drive(1, 1, 0, 1);
        chk("sat5_z_c", z_c, 1);
        chk("sat5_cnt_c", cnt_c, 1);
        drive(1, 1, 0, 1);
        chk("sat6_z_c", z_c, 1);
        chk("sat6_cnt_c", cnt_c, 2);
        drive(1, 1, 0, 1);
        chk("sat7_z_c", z_c, 1);
        chk("sat7_cnt_c", cnt_c, 3);
        chk("sat7_ovf_c", ovf_c, 0);

        // clear colliding with a match, then a clear alone
        drive(1, 1, 1, 1);
        chk("clr1_z_c", z_c, 1);
        chk("clr1_cnt_c", cnt_c, 3);
        chk("clr1_ovf_c", ovf_c, 1);
        drive(0, 0, 1, 1);
        chk("clr2_z_c", z_c, 0);
        chk("clr2_cnt_c", cnt_c, 1);
        chk("clr2_ovf_c", ovf_c, 0);
        drive(0, 0, 0, 1);
        chk("clr3_cnt_c", cnt_c, 0);
        chk("clr3_ovf_c", ovf_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
